isp_loader: RTL

In-system program loader that sits directly upstream of `RISC_V_Core`. It accepts a byte-serial program image and assembles little-endian 32-bit words. It writes them into program memory through the core's `isp_write`/`isp_address`/`isp_data` port while holding the core in reset. It then releases reset and pulses `start` with the entry address, replacing the `$readmemh` preload used by the instruction tests.

---
 rtl/isp_loader_pkg.sv | 28 ++
 rtl/isp_loader_if.sv | 12 +
 rtl/isp_word_packer.sv | 32 +++
 rtl/isp_loader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/isp_loader_pkg.sv
// Shared types and constants for the in-system program loader.
// The header and the program words use the same little-endian byte packing.
package isp_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef logic [7:0] isp_byte_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Compared at 33 bits so that a huge count can never wrap into range.
  function automatic logic exceeds_capacity(input logic [31:0] count,
                                            input int          addr_bits,
                                            input int          base);
    logic [32:0] cap;
    cap = 33'((64'd1 << addr_bits) - 64'(base));
    return {1'b0, count} > cap;
  endfunction

endpackage

// File: rtl/isp_loader_if.sv
// Byte-serial image stream: the source drives data/valid, the loader drives ready.
interface isp_loader_if;
  import isp_loader_pkg::*;

  isp_byte_t in_data;
  logic      in_valid;
  logic      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/isp_word_packer.sv
// Collects accepted bytes little-endian into a 32-bit word and pulses word_valid
// for one cycle after the last byte of each word lands.
module isp_word_packer
  import isp_loader_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        byte_en,
  input  isp_byte_t                   byte_in,
  output logic                        word_valid,
  output logic [8*BYTES_PER_WORD-1:0] word
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= byte_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));
      if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        // New bytes enter at the top, so byte 0 ends up in the low lane.
        word     <= {byte_in, word[8*BYTES_PER_WORD-1:8]};
      end
    end
  end

endmodule

// File: rtl/isp_loader.sv
// Loads a length-prefixed program image into core program memory while the core
// is held in reset, then releases the core with a one-cycle start pulse.
module isp_loader
  import isp_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12,
  parameter int PROG_BASE    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  isp_loader_if.slave             byte_if,
  output logic                    core_reset,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  state_t                      state;
  logic                        accept_en;
  logic [ADDRESS_BITS-1:0]     index;
  logic [ADDRESS_BITS-1:0]     last_index;
  logic                        load_take;
  logic                        byte_fire;
  logic                        word_valid;
  logic [8*BYTES_PER_WORD-1:0] word;
  logic [8*HDR_BYTES-1:0]      count;

  assign load_take        = load && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign byte_fire        = byte_if.in_valid && accept_en;
  assign byte_if.in_ready = accept_en;
  assign count            = word;

  isp_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (load_take),
    .byte_en    (byte_fire),
    .byte_in    (byte_if.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Write stage: each packed word is presented for the one cycle after its last byte.
  assign isp_write    = word_valid && (state == ST_LOAD);
  assign isp_address  = index;
  assign isp_data     = DATA_WIDTH'(word);
  assign prog_address = 20'(PROG_BASE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      accept_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
      start      <= 1'b0;
      index      <= '0;
      last_index <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (load) begin
            state      <= ST_HDR;
            accept_en  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        ST_HDR: begin
          if (word_valid) begin
            if (count == '0) begin
              state      <= ST_RUN;
              accept_en  <= 1'b0;
              core_reset <= 1'b0;
              start      <= 1'b1;
            end else if (exceeds_capacity(count, ADDRESS_BITS, PROG_BASE)) begin
              // Keep draining the stream so the source never stalls on a rejected image.
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              index      <= ADDRESS_BITS'(PROG_BASE);
              last_index <= ADDRESS_BITS'(count + 32'(PROG_BASE) - 32'd1);
            end
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            index <= index + ADDRESS_BITS'(1);
            if (index == last_index) begin
              state      <= ST_RUN;
              accept_en  <= 1'b0;
              core_reset <= 1'b0;
              start      <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
